// File: rtl/pipe_mult_pkg.sv
// pipe_mult_pkg: sizing helpers shared by the pipelined array multiplier.
// Optional build macro: PIPE_MULT_SIGNED_EN (per-beat two's-complement mode).
// Each module derives PROD_W and its stage_t layout from these helpers,
// because a package cannot see a module's WIDTH parameter.
package pipe_mult_pkg;

    // Partial-product rows handled by each stage, rounded up.
    function automatic int rows_per_stage(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    // Product width for a given operand width.
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

    // First row owned by stage k. Clamped so trailing stages may own no rows.
    function automatic int row_lo(input int k, input int width, input int stages);
        int lo;
        lo = k * rows_per_stage(width, stages);
        return (lo < width) ? lo : width;
    endfunction

    // One past the last row owned by stage k.
    function automatic int row_hi(input int k, input int width, input int stages);
        int hi;
        hi = (k + 1) * rows_per_stage(width, stages);
        return (hi < width) ? hi : width;
    endfunction

    // Packed bit count of stage_t: a, b, [sgn], psum, vld.
    function automatic int stage_w(input int width);
`ifdef PIPE_MULT_SIGNED_EN
        return 4 * width + 2;
`else
        return 4 * width + 1;
`endif
    endfunction

endpackage

// File: rtl/pipe_mult_if.sv
// pipe_mult_if: operand and product channels of the pipelined multiplier.
// Optional build macro: PIPE_MULT_SIGNED_EN (adds the sgn operand bit).
// master = operand issuer / result consumer, slave = the multiplier.
interface pipe_mult_if
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
`ifdef PIPE_MULT_SIGNED_EN
    logic                     sgn;
`endif
    logic                     in_valid;
    logic                     in_ready;
    logic [prod_w(WIDTH)-1:0] product;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
`ifdef PIPE_MULT_SIGNED_EN
        output sgn,
`endif
        output a, b, in_valid, out_ready,
        input  in_ready, product, out_valid
    );

    modport slave (
`ifdef PIPE_MULT_SIGNED_EN
        input  sgn,
`endif
        input  a, b, in_valid, out_ready,
        output in_ready, product, out_valid
    );

endinterface

// File: rtl/pipe_mult_stage.sv
// pipe_mult_stage: one pipeline stage of the array multiplier.
// Adds partial-product rows ROW_LO .. ROW_HI-1 onto the running sum and
// registers the result together with the operands and the valid bit.
// Optional build macro: PIPE_MULT_SIGNED_EN (row WIDTH-1 is subtracted for
// signed beats, Baugh-Wooley style, with a sign-extended multiplicand).
module pipe_mult_stage
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROW_LO = 0,
    parameter int ROW_HI = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      advance,
    input  logic [stage_w(WIDTH)-1:0] d_in,
    output logic [stage_w(WIDTH)-1:0] q
);

    localparam int PROD_W = prod_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
`ifdef PIPE_MULT_SIGNED_EN
        logic              sgn;
`endif
        logic [PROD_W-1:0] psum;
        logic              vld;
    } stage_t;

    stage_t            d;
    stage_t            nxt;
    stage_t            q_r;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] row;
    logic [PROD_W-1:0] sum;

    assign d = d_in;
    assign q = q_r;

    // Accumulate this stage's rows onto the incoming partial sum (2*WIDTH bits, MSB truncation).
    always_comb begin
        // NOTE: every variable gets a default before any conditional update, so no latch is inferred.
        a_ext = {{WIDTH{1'b0}}, d.a};
        row   = '0;
        sum   = d.psum;
`ifdef PIPE_MULT_SIGNED_EN
        if (d.sgn) begin
            a_ext = {{WIDTH{d.a[WIDTH-1]}}, d.a};
        end
`endif
        for (int i = ROW_LO; i < ROW_HI; i++) begin
            row = d.b[i] ? (a_ext << i) : '0;
`ifdef PIPE_MULT_SIGNED_EN
            // The multiplier's sign bit carries weight -2^(WIDTH-1) in two's complement.
            if (d.sgn && (i == WIDTH - 1)) begin
                sum = sum - row;
            end else begin
                sum = sum + row;
            end
`else
            sum = sum + row;
`endif
        end
        nxt      = d;
        nxt.psum = sum;
    end

    // Stage register: clears on reset, loads on a global advance, otherwise holds.
    always_ff @(posedge clk) begin
        // NOTE: the data fields clear along with vld so product reads 0 straight out of reset.
        if (rst) begin
            q_r <= '0;
        end else if (advance) begin
            // NOTE: non-blocking, so every stage samples its predecessor's pre-edge value.
            q_r <= nxt;
        end
    end

endmodule

// File: rtl/pipe_mult_n.sv
// pipe_mult_n: parametrised pipelined array multiplier with valid/ready
// handshake, global stall, clock-enable freeze and synchronous reset.
// Partial-product rows are spread over STAGES stages of pipe_mult_stage;
// product is driven straight from the last stage's running sum.
// Optional build macro: PIPE_MULT_SIGNED_EN (per-beat sgn travels with the data).
module pipe_mult_n
    import pipe_mult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      ena,
    pipe_mult_if.slave bus
);

    localparam int PROD_W = prod_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
`ifdef PIPE_MULT_SIGNED_EN
        logic              sgn;
`endif
        logic [PROD_W-1:0] psum;
        logic              vld;
    } stage_t;

    stage_t beat_in;
    stage_t stage_d [STAGES];
    stage_t stage_q [STAGES];
    logic   stall;
    logic   advance;

    // Global stall: the whole pipe holds while the oldest result waits downstream.
    assign stall        = stage_q[STAGES-1].vld && !bus.out_ready;
    assign advance      = ena && !stall;
    assign bus.in_ready = advance;

    assign bus.out_valid = stage_q[STAGES-1].vld;
    assign bus.product   = stage_q[STAGES-1].psum;

    // Pack the incoming operand beat into stage form; the running sum starts at zero.
    always_comb begin
        beat_in     = '0;
        beat_in.a   = bus.a;
        beat_in.b   = bus.b;
`ifdef PIPE_MULT_SIGNED_EN
        beat_in.sgn = bus.sgn;
`endif
        beat_in.vld = bus.in_valid;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign stage_d[k] = beat_in;
        end else begin : g_src
            assign stage_d[k] = stage_q[k-1];
        end

        pipe_mult_stage #(
            .WIDTH  (WIDTH),
            .ROW_LO (row_lo(k, WIDTH, STAGES)),
            .ROW_HI (row_hi(k, WIDTH, STAGES))
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .advance (advance),
            .d_in    (stage_d[k]),
            .q       (stage_q[k])
        );
    end

endmodule

// File: tb/tb_pipe_mult_n.sv
// tb_pipe_mult_n: self-checking bench for pipe_mult_n.
// Main instance WIDTH=8/STAGES=4 runs directed steps against a scoreboard;
// three further instances (4/1, 5/2, 32/8) take random beats.
// Optional build macro: PIPE_MULT_SIGNED_EN (adds the signed directed steps
// and random sgn in the sweep).
module tb_pipe_mult_n;

    logic clk;
    logic rst;
    logic ena;
    logic cur_sgn;

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance
    pipe_mult_if #(.WIDTH(8)) m ();
`ifdef PIPE_MULT_SIGNED_EN
    assign m.sgn = cur_sgn;
`endif

    pipe_mult_n #(.WIDTH(8), .STAGES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .bus (m)
    );

    // Sweep instances, driven through generic 32/64-bit bench arrays
    logic [31:0] sw_a  [3];
    logic [31:0] sw_b  [3];
    logic        sw_iv [3];
    logic        sw_or [3];
    logic        sw_sg [3];
    logic        sw_ir [3];
    logic        sw_ov [3];
    logic [63:0] sw_p  [3];
    int          sw_sent [3];
    logic [63:0] sw_q [3][$];
    int          sw_w [3] = '{4, 5, 32};

    pipe_mult_if #(.WIDTH(4))  s0 ();
    pipe_mult_if #(.WIDTH(5))  s1 ();
    pipe_mult_if #(.WIDTH(32)) s2 ();

    assign s0.a = sw_a[0][3:0];  assign s0.b = sw_b[0][3:0];
    assign s1.a = sw_a[1][4:0];  assign s1.b = sw_b[1][4:0];
    assign s2.a = sw_a[2];       assign s2.b = sw_b[2];
    assign s0.in_valid = sw_iv[0]; assign s0.out_ready = sw_or[0];
    assign s1.in_valid = sw_iv[1]; assign s1.out_ready = sw_or[1];
    assign s2.in_valid = sw_iv[2]; assign s2.out_ready = sw_or[2];
`ifdef PIPE_MULT_SIGNED_EN
    assign s0.sgn = sw_sg[0];
    assign s1.sgn = sw_sg[1];
    assign s2.sgn = sw_sg[2];
`endif
    assign sw_ir[0] = s0.in_ready;  assign sw_ov[0] = s0.out_valid;  assign sw_p[0] = 64'(s0.product);
    assign sw_ir[1] = s1.in_ready;  assign sw_ov[1] = s1.out_valid;  assign sw_p[1] = 64'(s1.product);
    assign sw_ir[2] = s2.in_ready;  assign sw_ov[2] = s2.out_valid;  assign sw_p[2] = s2.product;

    pipe_mult_n #(.WIDTH(4), .STAGES(1)) u_w4 (
        .clk (clk), .rst (rst), .ena (1'b1), .bus (s0)
    );
    pipe_mult_n #(.WIDTH(5), .STAGES(2)) u_w5 (
        .clk (clk), .rst (rst), .ena (1'b1), .bus (s1)
    );
    pipe_mult_n #(.WIDTH(32), .STAGES(8)) u_w32 (
        .clk (clk), .rst (rst), .ena (1'b1), .bus (s2)
    );

    // Scoreboard for the main instance
    logic [63:0] m_q   [$];
    logic [63:0] m_got [$];
    logic        m_acc;

    // Behavioural reference: plain multiplication modulo 2^(2w).
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] mask;
        sa = {32'd0, a};
        sb = {32'd0, b};
        if (s && a[w-1]) sa = sa - (64'd1 << w);
        if (s && b[w-1]) sb = sb - (64'd1 << w);
        mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        return (sa * sb) & mask;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One main-instance cycle: sample away from the edge, score, then advance to the next negedge.
    task automatic step();
        #1;
        m_acc = 1'b0;
        if (!rst) begin
            if (m.out_valid) begin
                check("sb_out_expected", 64'(m_q.size() != 0), 64'd1);
                if (m_q.size() != 0) begin
                    check("sb_product", m.product, m_q[0]);
                    if (m.out_ready && ena) begin
                        m_got.push_back(64'(m.product));
                        void'(m_q.pop_front());
                    end
                end
            end
            if (m.in_valid && m.in_ready) begin
                m_q.push_back(model(32'(m.a), 32'(m.b), cur_sgn, 8));
                m_acc = 1'b1;
            end
        end
        @(posedge clk);
        if (rst) m_q.delete();
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        int n;
        n          = 0;
        m.a        = a;
        m.b        = b;
        cur_sgn    = s;
        m.in_valid = 1'b1;
        m_acc      = 1'b0;
        while (!m_acc && n < 20) begin
            step();
            n++;
        end
        check("send_accepted", 64'(m_acc), 64'd1);
    endtask

    task automatic drain();
        int n;
        n           = 0;
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        while (m_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_empty", 64'(m_q.size()), 64'd0);
        cur_sgn = 1'b0;
    endtask

    initial begin
        int  idx;
        bit  done;
        logic [31:0] mk;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        ena         = 1'b1;
        cur_sgn     = 1'b0;
        m.a         = '0;
        m.b         = '0;
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            sw_a[j] = '0; sw_b[j] = '0; sw_iv[j] = 1'b0; sw_or[j] = 1'b1;
            sw_sg[j] = 1'b0; sw_sent[j] = 0;
        end

        // Power-on reset for two cycles
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        #1;
        check("reset_out_valid", 64'(m.out_valid), 64'd0);
        check("reset_product",   64'(m.product),   64'd0);
        check("reset_in_ready",  64'(m.in_ready),  64'd1);
        check("reset_w32_out_valid", 64'(sw_ov[2]), 64'd0);

        // Unsigned 255*255 with latency STAGES
        m.a = 8'd255; m.b = 8'd255; m.in_valid = 1'b1;
        step();
        check("lat_accept", 64'(m_acc), 64'd1);
        m.in_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check("lat_early_out_valid", 64'(m.out_valid), 64'd0);
            step();
        end
        #1;
        check("lat_out_valid", 64'(m.out_valid), 64'd1);
        check("lat_product",   64'(m.product),   64'hFE01);
        step();

        // Back-to-back unsigned patterns
        m_got.delete();
        send(8'd0,   8'd200, 1'b0);
        send(8'd1,   8'd1,   1'b0);
        send(8'd170, 8'd85,  1'b0);
        send(8'd128, 8'd2,   1'b0);
        drain();
        check("uns_count", 64'(m_got.size()), 64'd4);
        if (m_got.size() == 4) begin
            check("uns_zero",    m_got[0], 64'd0);
            check("uns_one",     m_got[1], 64'd1);
            check("uns_alt",     m_got[2], 64'h3872);
            check("uns_shift",   m_got[3], 64'h0100);
        end

`ifdef PIPE_MULT_SIGNED_EN
        // Signed beats interleaved with an unsigned one
        m_got.delete();
        send(8'h80, 8'h7F, 1'b1);
        send(8'hFF, 8'hFF, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        drain();
        check("sgn_count", 64'(m_got.size()), 64'd3);
        if (m_got.size() == 3) begin
            check("sgn_min_x_max",  m_got[0], 64'hC080);
            check("sgn_neg1_sq",    m_got[1], 64'h0001);
            check("sgn_then_uns",   m_got[2], 64'hFE01);
        end
`endif

        // Backpressure: out_ready low from the fifth cycle for four cycles
        m_got.delete();
        idx = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            m.a         = 8'(17 * idx + 3);
            m.b         = 8'(200 - 13 * idx);
            m.in_valid  = 1'b1;
            m.out_ready = !(k >= 4 && k < 8);
            if (k >= 4 && k < 8) begin
                #1;
                check("bp_in_ready_low", 64'(m.in_ready),  64'd0);
                check("bp_out_valid",    64'(m.out_valid), 64'd1);
            end
            step();
            if (m_acc) idx++;
        end
        check("bp_all_sent", 64'(idx), 64'd6);
        drain();
        check("bp_delivered", 64'(m_got.size()), 64'd6);

        // ena freeze for three cycles mid-stream
        m_got.delete();
        idx = 0;
        for (int k = 0; k < 40 && idx < 6; k++) begin
            m.a         = 8'(29 * idx + 7);
            m.b         = 8'(31 * idx + 1);
            m.in_valid  = 1'b1;
            m.out_ready = 1'b1;
            ena         = !(k >= 4 && k < 7);
            if (k >= 4 && k < 7) begin
                #1;
                check("frz_in_ready_low", 64'(m.in_ready),  64'd0);
                check("frz_out_valid",    64'(m.out_valid), 64'd1);
            end
            step();
            if (m_acc) idx++;
        end
        ena = 1'b1;
        check("frz_all_sent", 64'(idx), 64'd6);
        drain();
        check("frz_delivered", 64'(m_got.size()), 64'd6);

        // Reset mid-stream discards in-flight beats
        for (int k = 0; k < 6; k++) begin
            m.a = 8'(k + 5); m.b = 8'(k + 9); m.in_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        step();
        rst        = 1'b0;
        m.in_valid = 1'b0;
        #1;
        check("rst_mid_product",  64'(m.product),  64'd0);
        check("rst_mid_in_ready", 64'(m.in_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rst_mid_quiet", 64'(m.out_valid), 64'd0);
            step();
        end
        m_got.delete();
        send(8'd12, 8'd11, 1'b0);
        drain();
        check("rst_recover_count", 64'(m_got.size()), 64'd1);
        if (m_got.size() == 1) check("rst_recover_val", m_got[0], 64'd132);

        // WIDTH=4/STAGES=1: single-cycle latency
        sw_a[0] = 32'hF; sw_b[0] = 32'hD; sw_iv[0] = 1'b1; sw_or[0] = 1'b1;
        #1;
        check("w4_accept", 64'(sw_ir[0]), 64'd1);
        @(posedge clk); @(negedge clk);
        sw_iv[0] = 1'b0;
        #1;
        check("w4_latency1_valid", 64'(sw_ov[0]), 64'd1);
        check("w4_product",        sw_p[0],       64'd195);
        @(posedge clk); @(negedge clk);
        #1;
        check("w4_drained", 64'(sw_ov[0]), 64'd0);

        // Random sweep, 1000 beats per instance with random backpressure
        done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            for (int j = 0; j < 3; j++) begin
                mk       = (sw_w[j] == 32) ? 32'hFFFF_FFFF : ((32'd1 << sw_w[j]) - 32'd1);
                sw_a[j]  = $urandom & mk;
                sw_b[j]  = $urandom & mk;
                sw_iv[j] = (sw_sent[j] < 1000) && ($urandom_range(0, 3) != 0);
                sw_or[j] = ($urandom_range(0, 3) != 0);
`ifdef PIPE_MULT_SIGNED_EN
                sw_sg[j] = 1'($urandom_range(0, 1));
`endif
            end
            #1;
            for (int j = 0; j < 3; j++) begin
                if (sw_ov[j]) begin
                    check("sw_out_expected", 64'(sw_q[j].size() != 0), 64'd1);
                    if (sw_q[j].size() != 0) begin
                        check("sw_product", sw_p[j], sw_q[j][0]);
                        if (sw_or[j]) void'(sw_q[j].pop_front());
                    end
                end
                if (sw_iv[j] && sw_ir[j]) begin
                    sw_q[j].push_back(model(sw_a[j], sw_b[j], sw_sg[j], sw_w[j]));
                    sw_sent[j]++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            done = 1'b1;
            for (int j = 0; j < 3; j++) begin
                if (sw_sent[j] < 1000 || sw_q[j].size() != 0) done = 1'b0;
            end
        end
        for (int j = 0; j < 3; j++) begin
            check("sw_sent",    64'(sw_sent[j]),     64'd1000);
            check("sw_drained", 64'(sw_q[j].size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mult_n.md
Name: pipe_mult_n

Overview:
- Parametrised pipelined array multiplier; next generation of the team's fixed 4x4 single-register multiplier.
- Partial-product rows are split across STAGES register stages. Each stage carries a valid bit.
- Adds a valid/ready handshake with backpressure, clock-enable freeze and per-transaction signed mode.
- Sits between operand-issue logic and the result FIFO in the datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32); product is 2*WIDTH bits.
- STAGES, 4, pipeline register stages (1..WIDTH); rows per stage = ceil(WIDTH/STAGES).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  global enable; low freezes all pipeline state.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned (present only with PIPE_MULT_SIGNED_EN).
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- product  out  2*WIDTH  result of the oldest beat.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.

Behaviour:
- Reset, synchronous and active-high, sampled at a clk edge: all stage valid bits, out_valid and product go to 0. Stage data registers clear to 0. rst overrides ena and all handshakes. Reset mid-operation discards every in-flight beat; in_ready is 1 in the cycle after reset is released (given ena=1).
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- stall = out_valid && !out_ready. in_ready = ena && !stall. This is a global stall: all stages hold together, with no bubble collapsing.
- Advance: when ena=1 and stall=0, every stage register loads from its predecessor. Stage 0 loads the input beat with valid = in_valid.
- Latency: STAGES cycles from the accept edge to out_valid=1, with no stall. Throughput is 1 beat/cycle.
- Stage k state:
  - Registered a, b, sgn.
  - Running partial sum of width 2*WIDTH.
  - Valid bit.
- Stage k adds rows k*R .. min((k+1)*R, WIDTH)-1, where R = rows per stage. Row i is (a AND b[i]) shifted left by i.
- Product: the last stage's partial sum drives product directly; no extra output register.
- Unsigned mode: exact a*b modulo 2^(2*WIDTH) (no overflow is possible).
- Signed mode: Baugh-Wooley, i.e. row WIDTH-1 is subtracted. The result equals the signed a*b, exact in 2*WIDTH bits.
- product holds its value while stalled or ena=0. When out_valid=0, product is don't-care but stable.
- ena=0: no state changes, in_ready=0. out_valid keeps its value; an output transfer while ena=0 is not consumed (the beat remains).
- Simultaneous accept and drain: both occur; occupancy is unchanged.
- Full: all STAGES valid and stall → in_ready=0. Empty: out_valid=0.
- Width rule: all internal sums are 2*WIDTH bits, truncated at the MSB; no sign-extension beyond 2*WIDTH.

Optional Feature:
- PIPE_MULT_SIGNED_EN defined: sgn port exists; mode is per beat and travels with the data through the pipeline.
- Macro undefined: the sgn port is absent, all beats are unsigned, and the Baugh-Wooley correction logic is not built.

Decomposition:
- Package pipe_mult_pkg holds:
  - function rows_per_stage(WIDTH, STAGES);
  - localparam PROD_W = 2*WIDTH;
  - typedef stage_t struct {a, b, sgn, psum, vld}.
- One sub-module, pipe_mult_stage: combinational row adder for a given row range plus its register. It is instantiated STAGES times via generate.

Test Plan:
- Reset: rst=1 for 2 cycles during streaming → next cycle out_valid=0, product=0, in_ready=1. No pre-reset result ever appears.
- Unsigned, WIDTH=8, STAGES=4: a=255, b=255 accepted at cycle t → out_valid at t+4, product=65025 (0xFE01).
- Signed (macro on): a=0x80 (-128), b=0x7F (127), sgn=1 → product=0xC080 (-16256). Next beat a=0xFF, b=0xFF, sgn=1 → product=0x0001.
- Backpressure: 6 back-to-back beats, out_ready=0 from cycle 5 → in_ready falls the same cycle; all 6 results are delivered in order with none lost or duplicated once out_ready=1.
- ena freeze: ena=0 for 3 cycles mid-stream → valid bits, product and in_ready=0 are held; the sequence resumes unchanged when ena=1.
- Parameter sweep: WIDTH=4/STAGES=1 (latency 1), WIDTH=5/STAGES=2 (uneven row split), WIDTH=32/STAGES=8, each checked with 1000 random beats against a behavioural model.
